// File: rtl/pipe_stage_chain_if.sv
// ============================================================================
// Module      : pipe_stage_chain_if
// Description : Handshake/data bundle between the hazard unit, the pipeline
//               front end and the generic pipeline register chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_chain_if #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 32
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic [STAGES-1:0]        stall;
  logic [STAGES-1:0]        flush;
  logic                     cnt_clr;
  logic [STAGES-1:0]        stage_valid;
  logic [STAGES*DATA_W-1:0] stage_data;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [CNT_W-1:0]         retire_cnt;
  logic [CNT_W-1:0]         bubble_cnt;

  // Front end / hazard unit side
  modport master (
    output in_valid, in_data, stall, flush, cnt_clr,
    input  in_ready, stage_valid, stage_data, out_valid, out_data,
           retire_cnt, bubble_cnt
  );

  // Pipeline chain side
  modport slave (
    input  in_valid, in_data, stall, flush, cnt_clr,
    output in_ready, stage_valid, stage_data, out_valid, out_data,
           retire_cnt, bubble_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_chain.sv
// ============================================================================
// Module      : pipe_stage_chain
// Description : Generic N-stage pipeline register chain with valid bits,
//               stall propagation, bubble insertion, per-stage flush and
//               saturating retire/bubble counters on the last stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_chain #(
  parameter int DATA_W      = 32,
  parameter int STAGES      = 4,
  parameter int CNT_W       = 32,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_chain_if.slave pipe
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  generate
    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
      $error("pipe_stage_chain: STAGES must lie in 2..8");
    end
  endgenerate

  logic [STAGES-1:0]        hold;
  logic [STAGES-1:0]        valid_q, valid_d;
  logic [DATA_W-1:0]        data_q [STAGES];
  logic [DATA_W-1:0]        data_d [STAGES];
  logic [STAGES-1:0]        src_valid;
  logic [DATA_W-1:0]        src_data [STAGES];
  logic [STAGES-1:0]        ins_bubble;
  logic                     depart;
  logic [CNT_W-1:0]         retire_q, retire_d;
  logic [CNT_W-1:0]         bubble_q, bubble_d;
  logic [STAGES*DATA_W-1:0] stage_data_flat;

  // A bubble either clears the payload or leaves the old one in place
  function automatic logic [DATA_W-1:0] bubble_of(input logic [DATA_W-1:0] cur);
    return ZERO_BUBBLE ? '0 : cur;
  endfunction

  // A stall at stage j freezes every stage at or below j
  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_hold
      assign hold[g] = |pipe.stall[STAGES-1:g];
    end
  endgenerate

  // Upstream source of each stage, and whether it must take a bubble instead
  always_comb begin
    src_valid     = '0;
    ins_bubble    = '0;
    for (int k = 0; k < STAGES; k++) src_data[k] = '0;
    src_valid[0]  = pipe.in_valid;
    src_data[0]   = pipe.in_valid ? pipe.in_data : bubble_of(data_q[0]);
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k]  = valid_q[k-1];
      src_data[k]   = data_q[k-1];
      ins_bubble[k] = hold[k-1];
    end
  end

  // Per-stage next state: flush > hold > bubble insertion > load
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) data_d[k] = data_q[k];
    for (int k = 0; k < STAGES; k++) begin
      if (pipe.flush[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = bubble_of(data_q[k]);
      end else if (hold[k]) begin
        valid_d[k] = valid_q[k];
        data_d[k]  = data_q[k];
      end else if (ins_bubble[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = bubble_of(data_q[k]);
      end else begin
        valid_d[k] = src_valid[k];
        data_d[k]  = src_data[k];
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  // A slot leaves the last stage unless it is held there or flushed away
  assign depart = ~hold[STAGES-1] & ~pipe.flush[STAGES-1];

  // Saturating counters; clear beats increment
  always_comb begin
    retire_d = retire_q;
    bubble_d = bubble_q;
    if (pipe.cnt_clr) begin
      retire_d = '0;
      bubble_d = '0;
    end else if (depart) begin
      if (valid_q[STAGES-1]) begin
        if (retire_q != C_CNT_MAX) retire_d = retire_q + CNT_W'(1);
      end else begin
        if (bubble_q != C_CNT_MAX) bubble_d = bubble_q + CNT_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end

  // Flatten stage payloads onto the output bus
  always_comb begin
    stage_data_flat = '0;
    for (int k = 0; k < STAGES; k++) stage_data_flat[k*DATA_W +: DATA_W] = data_q[k];
  end

  assign pipe.in_ready    = ~hold[0];
  assign pipe.stage_valid = valid_q;
  assign pipe.stage_data  = stage_data_flat;
  assign pipe.out_valid   = valid_q[STAGES-1];
  assign pipe.out_data    = data_q[STAGES-1];
  assign pipe.retire_cnt  = retire_q;
  assign pipe.bubble_cnt  = bubble_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
// ============================================================================
// Module      : tb_pipe_stage_chain
// Description : Self-checking bench for pipe_stage_chain (4 stages, 4-bit
//               counters): hand-derived vector table, saturation sequence and
//               randomized traffic against a slot-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_chain;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_chain_if #(.DATA_W(32), .STAGES(4), .CNT_W(4)) bus ();

  pipe_stage_chain #(
    .DATA_W(32), .STAGES(4), .CNT_W(4), .ZERO_BUBBLE(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (bus)
  );

  typedef struct {
    logic        rst, iv;
    logic [31:0] id;
    logic [3:0]  st, fl;
    logic        clr, rdy;
    logic [3:0]  sv;
    logic [31:0] d3, d2, d1, d0;
    logic [3:0]  r, b;
  } vec_t;

  vec_t tbl[$];

  // Reference model: slot contents per stage
  logic        mv [4];
  logic [31:0] md [4];
  int          mr, mb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic r_n, iv, input logic [31:0] id,
                              input logic [3:0] st, fl, input logic clr, rdy,
                              input logic [3:0] sv, input logic [31:0] d3, d2, d1, d0,
                              input logic [3:0] r, b);
    vec_t v;
    v.rst = r_n; v.iv = iv; v.id = id; v.st = st; v.fl = fl; v.clr = clr; v.rdy = rdy;
    v.sv = sv; v.d3 = d3; v.d2 = d2; v.d1 = d1; v.d0 = d0; v.r = r; v.b = b;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic r_n, iv, input logic [31:0] id,
                       input logic [3:0] st, fl, input logic clr);
    rst = r_n; bus.in_valid = iv; bus.in_data = id;
    bus.stall = st; bus.flush = fl; bus.cnt_clr = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Next state from the rules: the highest stalled stage h freezes 0..h,
  // stage h+1 receives a bubble, everything above shifts; flush overrides.
  function automatic void model_step(input logic r_n, iv, input logic [31:0] id,
                                     input logic [3:0] st, fl, input logic clr);
    int          h;
    logic        nv [4];
    logic [31:0] nd [4];
    if (!r_n) begin
      for (int k = 0; k < 4; k++) begin mv[k] = 1'b0; md[k] = '0; end
      mr = 0; mb = 0;
      return;
    end
    h = -1;
    for (int k = 0; k < 4; k++) if (st[k]) h = k;
    if (clr) begin
      mr = 0; mb = 0;
    end else if (h != 3 && !fl[3]) begin
      if (mv[3]) begin if (mr < 15) mr++; end
      else begin if (mb < 15) mb++; end
    end
    for (int k = 0; k < 4; k++) begin
      if (k <= h)                 begin nv[k] = mv[k];   nd[k] = md[k];   end
      else if (h >= 0 && k == h+1) begin nv[k] = 1'b0;    nd[k] = '0;      end
      else if (k == 0)            begin nv[k] = iv;      nd[k] = iv ? id : '0; end
      else                        begin nv[k] = mv[k-1]; nd[k] = md[k-1]; end
      if (fl[k]) begin nv[k] = 1'b0; nd[k] = '0; end
    end
    for (int k = 0; k < 4; k++) begin mv[k] = nv[k]; md[k] = nd[k]; end
  endfunction

  task automatic cmp_model;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rand stage_valid[%0d]", k), 64'(bus.stage_valid[k]), 64'(mv[k]));
      chk($sformatf("rand stage_data[%0d]", k), 64'(bus.stage_data[k*32 +: 32]), 64'(md[k]));
    end
    chk("rand out_valid", 64'(bus.out_valid), 64'(mv[3]));
    chk("rand out_data", 64'(bus.out_data), 64'(md[3]));
    chk("rand retire_cnt", 64'(bus.retire_cnt), 64'(mr));
    chk("rand bubble_cnt", 64'(bus.bubble_cnt), 64'(mb));
  endtask

  initial begin
    logic        r_n, iv, clr;
    logic [31:0] id;
    logic [3:0]  st, fl;

    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);

    //  rst iv id  stall   flush   clr rdy sv      d3  d2  d1  d0  r  b
    add(0, 1, 99, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  0, 0); // reset, word dropped
    add(0, 0, 0,  4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  0, 0);
    add(1, 1, 1,  4'b0000, 4'b0000, 0, 1, 4'b0001, 0,  0,  0,  1,  0, 1); // fill
    add(1, 1, 2,  4'b0000, 4'b0000, 0, 1, 4'b0011, 0,  0,  1,  2,  0, 2);
    add(1, 1, 3,  4'b0000, 4'b0000, 0, 1, 4'b0111, 0,  1,  2,  3,  0, 3);
    add(1, 1, 4,  4'b0000, 4'b0000, 0, 1, 4'b1111, 1,  2,  3,  4,  0, 4); // first out
    add(1, 1, 5,  4'b0000, 4'b0000, 0, 1, 4'b1111, 2,  3,  4,  5,  1, 4);
    add(1, 1, 6,  4'b0000, 4'b0000, 0, 1, 4'b1111, 3,  4,  5,  6,  2, 4);
    add(1, 1, 7,  4'b0000, 4'b0000, 0, 1, 4'b1111, 4,  5,  6,  7,  3, 4);
    add(1, 1, 8,  4'b0000, 4'b0000, 0, 1, 4'b1111, 5,  6,  7,  8,  4, 4);
    add(1, 1, 9,  4'b0000, 4'b0000, 0, 1, 4'b1111, 6,  7,  8,  9,  5, 4); // 5 retired
    add(1, 1, 10, 4'b0000, 4'b0000, 0, 1, 4'b1111, 7,  8,  9,  10, 6, 4);
    add(1, 1, 11, 4'b0000, 4'b0000, 0, 1, 4'b1111, 8,  9,  10, 11, 7, 4);
    add(1, 1, 12, 4'b0000, 4'b0000, 0, 1, 4'b1111, 9,  10, 11, 12, 8, 4);
    add(1, 1, 13, 4'b0000, 4'b0000, 0, 1, 4'b1111, 10, 11, 12, 13, 9, 4);
    add(1, 1, 14, 4'b0010, 4'b0000, 0, 0, 4'b1011, 11, 0,  12, 13, 10, 4); // load-use stall
    add(1, 1, 14, 4'b0000, 4'b0000, 0, 1, 4'b0111, 0,  12, 13, 14, 11, 4);
    add(1, 1, 15, 4'b0000, 4'b0000, 0, 1, 4'b1111, 12, 13, 14, 15, 11, 5); // bubble left
    add(1, 1, 20, 4'b0000, 4'b0000, 0, 1, 4'b1111, 13, 14, 15, 20, 12, 5);
    add(1, 1, 21, 4'b0000, 4'b0000, 0, 1, 4'b1111, 14, 15, 20, 21, 13, 5);
    add(1, 1, 22, 4'b0000, 4'b0000, 0, 1, 4'b1111, 15, 20, 21, 22, 14, 5);
    add(1, 1, 23, 4'b0000, 4'b0000, 1, 1, 4'b1111, 20, 21, 22, 23, 0,  0); // clr beats retire
    add(1, 1, 24, 4'b0000, 4'b0011, 0, 1, 4'b1100, 21, 22, 0,  0,  1,  0); // branch flush
    add(1, 0, 0,  4'b0000, 4'b0000, 0, 1, 4'b1000, 22, 0,  0,  0,  2,  0);
    add(1, 0, 0,  4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  3,  0);
    add(1, 1, 30, 4'b0000, 4'b0000, 0, 1, 4'b0001, 0,  0,  0,  30, 3,  1);
    add(1, 1, 31, 4'b0000, 4'b0000, 0, 1, 4'b0011, 0,  0,  30, 31, 3,  2);
    add(1, 1, 32, 4'b0000, 4'b0000, 0, 1, 4'b0111, 0,  30, 31, 32, 3,  3);
    add(1, 1, 33, 4'b0000, 4'b0000, 0, 1, 4'b1111, 30, 31, 32, 33, 3,  4);
    add(1, 1, 34, 4'b0100, 4'b0100, 0, 0, 4'b0011, 0,  0,  32, 33, 4,  4); // stall+flush
    add(1, 1, 34, 4'b0000, 4'b0000, 0, 1, 4'b0111, 0,  32, 33, 34, 4,  5);
    add(1, 1, 35, 4'b0000, 4'b0000, 0, 1, 4'b1111, 32, 33, 34, 35, 4,  6);
    add(0, 1, 36, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  0,  0); // mid-run reset
    add(1, 0, 0,  4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  0,  1);
    add(1, 0, 0,  4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  0,  2);
    add(1, 0, 0,  4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  0,  3);
    add(1, 0, 0,  4'b0000, 4'b0000, 0, 1, 4'b0000, 0,  0,  0,  0,  0,  4);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].id, tbl[i].st, tbl[i].fl, tbl[i].clr);
      #1;
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].rdy));
      tick();
      chk($sformatf("vec%0d stage_valid", i), 64'(bus.stage_valid), 64'(tbl[i].sv));
      chk($sformatf("vec%0d stage0", i), 64'(bus.stage_data[31:0]),   64'(tbl[i].d0));
      chk($sformatf("vec%0d stage1", i), 64'(bus.stage_data[63:32]),  64'(tbl[i].d1));
      chk($sformatf("vec%0d stage2", i), 64'(bus.stage_data[95:64]),  64'(tbl[i].d2));
      chk($sformatf("vec%0d stage3", i), 64'(bus.stage_data[127:96]), 64'(tbl[i].d3));
      chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].sv[3]));
      chk($sformatf("vec%0d out_data", i), 64'(bus.out_data), 64'(tbl[i].d3));
      chk($sformatf("vec%0d retire_cnt", i), 64'(bus.retire_cnt), 64'(tbl[i].r));
      chk($sformatf("vec%0d bubble_cnt", i), 64'(bus.bubble_cnt), 64'(tbl[i].b));
    end

    // Saturation: chain empty with bubble_cnt=4; 4 more bubbles leave, then
    // 26 words retire, well past the 4-bit ceiling.
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b1, 32'(100 + i), '0, '0, 1'b0);
      tick();
    end
    chk("sat retire_cnt", 64'(bus.retire_cnt), 64'd15);
    chk("sat bubble_cnt", 64'(bus.bubble_cnt), 64'd8);
    chk("sat out_data", 64'(bus.out_data), 64'd126);
    drive(1'b1, 1'b1, 32'd130, '0, '0, 1'b1);
    tick();
    chk("clr retire_cnt", 64'(bus.retire_cnt), 64'd0);
    chk("clr bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
    drive(1'b1, 1'b1, 32'd131, '0, '0, 1'b0);
    tick();
    chk("post-clr retire_cnt", 64'(bus.retire_cnt), 64'd1);

    // Randomized traffic against the reference model, starting from reset
    for (int i = 0; i < 3000; i++) begin
      r_n = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      iv  = 1'($urandom_range(0, 1));
      id  = $urandom;
      st  = '0;
      fl  = '0;
      for (int k = 0; k < 4; k++) begin
        st[k] = ($urandom_range(0, 7) == 0);
        fl[k] = ($urandom_range(0, 9) == 0);
      end
      clr = ($urandom_range(0, 31) == 0);
      drive(r_n, iv, id, st, fl, clr);
      #1;
      chk("rand in_ready", 64'(bus.in_ready), 64'(st == 4'b0000));
      model_step(r_n, iv, id, st, fl, clr);
      tick();
      cmp_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
